// File: rtl/poly_small_mkgauss.sv
// poly_small_mkgauss
// Builds one small polynomial from a stream of Gaussian samples. Each sample
// is either rejected or written out as the next coefficient. A sample is
// rejected when it is outside +/-limit. The last coefficient is also rejected
// when it would make the sum of all coefficient LSBs even. One sample_req
// pulse is issued for every consumed sample, so only one request is ever
// outstanding.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   start              one-cycle pulse; begins a run when idle
//   logn_sel           0: n=512, limit 31   1: n=1024, limit 15
//   val_valid, val     Gaussian sample strobe and signed 32-bit value
//   sample_req         one-cycle request for the next sample
//   coef_we/addr/data  coefficient write port (data = val[7:0])
//   busy, done         run in progress / last coefficient written
//   reject_cnt         rejected samples in this run, saturating
//
// state | meaning
// IDLE  | waiting for start
// WAIT  | sample requested, waiting for val_valid
// FIN   | last coefficient written; one cycle, then back to IDLE

module poly_small_mkgauss (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               logn_sel,
  input  logic               val_valid,
  input  logic signed [31:0] val,
  output logic               sample_req,
  output logic               coef_we,
  output logic [9:0]         coef_addr,
  output logic signed [7:0]  coef_data,
  output logic               busy,
  output logic               done,
  output logic [15:0]        reject_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, FIN} state_t;

  state_t            state_q;
  logic [9:0]        u_q;
  logic              mod2_q;
  logic              big_q;        // latched ring size: 1 -> n=1024
  logic              sample_req_q;
  logic              coef_we_q;
  logic [9:0]        coef_addr_q;
  logic signed [7:0] coef_data_q;
  logic              busy_q;
  logic              done_q;
  logic [15:0]       reject_cnt_q;

  logic signed [31:0] lim;
  logic signed [31:0] neg_lim;
  logic               last_u;
  logic               range_bad;
  logic               par_bad;

  always_comb begin
    lim       = big_q ? 32'sd15 : 32'sd31;
    neg_lim   = -lim;
    last_u    = big_q ? (u_q == 10'd1023) : (u_q == 10'd511);
    range_bad = (val < neg_lim) || (val > lim);
    // The final coefficient must make the total LSB parity odd.
    par_bad   = last_u && ((mod2_q ^ val[0]) == 1'b0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      u_q          <= '0;
      mod2_q       <= 1'b0;
      big_q        <= 1'b0;
      sample_req_q <= 1'b0;
      coef_we_q    <= 1'b0;
      coef_addr_q  <= '0;
      coef_data_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      reject_cnt_q <= '0;
    end else begin
      sample_req_q <= 1'b0;
      coef_we_q    <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q       <= 1'b1;
            sample_req_q <= 1'b1;
            u_q          <= '0;
            mod2_q       <= 1'b0;
            reject_cnt_q <= '0;
            big_q        <= logn_sel;
            state_q      <= WAIT;
          end
        end
        WAIT: begin
          if (val_valid) begin
            if (range_bad || par_bad) begin
              if (reject_cnt_q != 16'hFFFF)
                reject_cnt_q <= reject_cnt_q + 16'd1;
              sample_req_q <= 1'b1;
            end else begin
              coef_we_q   <= 1'b1;
              coef_addr_q <= u_q;
              coef_data_q <= val[7:0];
              if (last_u) begin
                done_q  <= 1'b1;
                state_q <= FIN;
              end else begin
                mod2_q       <= mod2_q ^ val[0];
                u_q          <= u_q + 10'd1;
                sample_req_q <= 1'b1;
              end
            end
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sample_req = sample_req_q;
  assign coef_we    = coef_we_q;
  assign coef_addr  = coef_addr_q;
  assign coef_data  = coef_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign reject_cnt = reject_cnt_q;

endmodule
